// File: rtl/uart_rx_fifo_if.sv
// Byte handshake bundle between the UART receiver, the RX FIFO and the datapath read mux.
// slave = FIFO side, master = the UART/datapath side that drives it.
interface uart_rx_fifo_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// Receive-byte FIFO between the UART DataOut handshake and the datapath read mux.
// Optional occupancy port enabled by defining UART_RX_FIFO_COUNT_EN.
module uart_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
`ifdef UART_RX_FIFO_COUNT_EN
  output logic [$clog2(DEPTH):0]   count,
`endif
  uart_rx_fifo_if.slave            bus
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ZERO = {(AW+1){1'b0}};
  localparam logic [AW:0] PTR_ONE  = {{AW{1'b0}}, 1'b1};

  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;
  logic [AW:0]      wr_ptr_s;
  logic [AW:0]      rd_ptr_s;
  logic             full_r;
  logic             empty_r;
  logic             full_s;
  logic             empty_s;
  logic             push_s;
  logic             pop_s;
  logic [WIDTH-1:0] mem_r [DEPTH];

  function automatic logic ptr_full(input logic [AW:0] wp, input logic [AW:0] rp);
    return (wp[AW-1:0] == rp[AW-1:0]) && (wp[AW] != rp[AW]);
  endfunction

  function automatic logic ptr_empty(input logic [AW:0] wp, input logic [AW:0] rp);
    return wp == rp;
  endfunction

  // Handshakes qualify only on registered flags, so in_ready never sees out_ready.
  assign push_s        = bus.in_valid && !full_r && !flush;
  assign pop_s         = bus.out_ready && !empty_r && !flush;
  assign bus.in_ready  = !full_r;
  assign bus.out_valid = !empty_r;
  assign bus.out_data  = mem_r[rd_ptr_r[AW-1:0]];

  // Next pointer values; flush wins over any push or pop in the same cycle.
  always_comb begin
    wr_ptr_s = wr_ptr_r;
    rd_ptr_s = rd_ptr_r;
    if (flush) begin
      wr_ptr_s = PTR_ZERO;
      rd_ptr_s = PTR_ZERO;
    end else begin
      if (push_s) begin
        wr_ptr_s = wr_ptr_r + PTR_ONE;
      end else begin
        wr_ptr_s = wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_s = rd_ptr_r + PTR_ONE;
      end else begin
        rd_ptr_s = rd_ptr_r;
      end
    end
  end

  // Status flags precomputed from next pointers so they can be registered.
  always_comb begin
    full_s  = ptr_full(wr_ptr_s, rd_ptr_s);
    empty_s = ptr_empty(wr_ptr_s, rd_ptr_s);
  end

  // Pointer and flag state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
    end else begin
      wr_ptr_r <= wr_ptr_s;
      rd_ptr_r <= rd_ptr_s;
      full_r   <= full_s;
      empty_r  <= empty_s;
    end
  end

  // Storage array; contents are meaningless until written, so no reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= bus.in_data;
    end
  end

`ifdef UART_RX_FIFO_COUNT_EN
  logic [AW:0] count_r;
  logic [AW:0] count_s;

  assign count_s = wr_ptr_s - rd_ptr_s;
  assign count   = count_r;

  // Registered occupancy, aligned with the pointer update.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_r <= PTR_ZERO;
    end else begin
      count_r <= count_s;
    end
  end
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: a vector table plus directed stream, flush and reset sequences.
module tb_uart_rx_fifo;

  logic       clk;
  logic       rst;
  logic       flush;
  logic [3:0] count;
  int         total;
  int         bad;

  uart_rx_fifo_if #(.WIDTH(8)) bus ();

`ifdef UART_RX_FIFO_COUNT_EN
  uart_rx_fifo #(.WIDTH(8), .DEPTH(8)) dut (
    .clk(clk), .rst(rst), .flush(flush), .count(count), .bus(bus.slave)
  );
`else
  uart_rx_fifo #(.WIDTH(8), .DEPTH(8)) dut (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus.slave)
  );
  assign count = 4'd0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       iv;
    logic [7:0] d;
    logic       ordy;
    logic       ir;
    logic       ov;
    logic [7:0] ed;
    logic [3:0] cnt;
  } vec_t;

  vec_t vecs [21];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_cnt(input string name, input logic [3:0] exp);
`ifdef UART_RX_FIFO_COUNT_EN
    chk(name, {28'd0, count}, {28'd0, exp});
`endif
  endtask

  task automatic setv(input int i, input logic iv, input logic [7:0] d, input logic ordy,
                      input logic ir, input logic ov, input logic [7:0] ed, input logic [3:0] c);
    vecs[i].iv = iv; vecs[i].d = d; vecs[i].ordy = ordy;
    vecs[i].ir = ir; vecs[i].ov = ov; vecs[i].ed = ed; vecs[i].cnt = c;
  endtask

  task automatic step(input logic iv, input logic [7:0] d, input logic ordy, input logic fl);
    bus.in_valid  = iv;
    bus.in_data   = d;
    bus.out_ready = ordy;
    flush         = fl;
    @(posedge clk);
    #1;
  endtask

  int rx_idx;

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    flush = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.out_ready = 1'b0;

    // Table: single byte, fill to full, held byte accepted after one pop, drain.
    setv(0, 1'b1, 8'h41, 1'b0, 1'b1, 1'b1, 8'h41, 4'd1);
    setv(1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 4'd0);
    for (int i = 0; i < 8; i++)
      setv(2 + i, 1'b1, 8'(i), 1'b0, (i < 7), 1'b1, 8'h00, 4'(i + 1));
    setv(10, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b1, 8'h00, 4'd8);
    setv(11, 1'b1, 8'hFF, 1'b1, 1'b1, 1'b1, 8'h01, 4'd7);
    setv(12, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b1, 8'h01, 4'd8);
    for (int k = 0; k < 7; k++)
      setv(13 + k, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, (k < 6) ? 8'(8'h02 + k) : 8'hFF, 4'(7 - k));
    setv(20, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 4'd0);

    #12;
    chk("reset_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk_cnt("reset_count", 4'd0);
    rst = 1'b1;

    for (int i = 0; i < 21; i++) begin
      step(vecs[i].iv, vecs[i].d, vecs[i].ordy, 1'b0);
      chk($sformatf("vec%0d_in_ready", i), {31'd0, bus.in_ready}, {31'd0, vecs[i].ir});
      chk($sformatf("vec%0d_out_valid", i), {31'd0, bus.out_valid}, {31'd0, vecs[i].ov});
      if (vecs[i].ov)
        chk($sformatf("vec%0d_out_data", i), {24'd0, bus.out_data}, {24'd0, vecs[i].ed});
      chk_cnt($sformatf("vec%0d_count", i), vecs[i].cnt);
    end

    // Stream 20 bytes with both sides always ready; pointers wrap twice.
    rx_idx = 0;
    for (int k = 0; k < 22; k++) begin
      step(k < 20, 8'(8'h10 + k), 1'b1, 1'b0);
      if (bus.out_valid) begin
        chk($sformatf("stream_byte%0d", rx_idx), {24'd0, bus.out_data}, 32'(8'h10 + rx_idx));
        rx_idx = rx_idx + 1;
      end
`ifdef UART_RX_FIFO_COUNT_EN
      chk($sformatf("stream_count_le1_c%0d", k), {31'd0, (count <= 4'd1)}, 32'd1);
`endif
    end
    chk("stream_received", rx_idx, 32'd20);

    // Flush with a concurrent push: all stored bytes and the pushed byte are discarded.
    step(1'b1, 8'hA1, 1'b0, 1'b0);
    step(1'b1, 8'hA2, 1'b0, 1'b0);
    step(1'b1, 8'hA3, 1'b0, 1'b0);
    chk_cnt("pre_flush_count", 4'd3);
    step(1'b1, 8'h55, 1'b0, 1'b1);
    chk("flush_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("flush_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk_cnt("flush_count", 4'd0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("flush_no_55", {31'd0, bus.out_valid}, 32'd0);
    step(1'b1, 8'h99, 1'b0, 1'b0);
    chk("post_flush_data", {24'd0, bus.out_data}, 32'h99);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("post_flush_empty", {31'd0, bus.out_valid}, 32'd0);

    // Asynchronous reset between edges with five bytes stored.
    for (int k = 0; k < 5; k++)
      step(1'b1, 8'(8'h60 + k), 1'b0, 1'b0);
    chk("pre_rst_data", {24'd0, bus.out_data}, 32'h60);
    bus.in_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("async_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk_cnt("async_rst_count", 4'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    step(1'b1, 8'h7E, 1'b0, 1'b0);
    chk("post_rst_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("post_rst_data", {24'd0, bus.out_data}, 32'h7E);
    chk_cnt("post_rst_count", 4'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the data byte width.
REQ-002 The block SHALL have parameter DEPTH, default 8, giving the number of entries; DEPTH SHALL be a power of two and at least 2.
REQ-003 Port clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst  input  1  reset, asynchronous and active-low.
REQ-005 Port in_data  input  WIDTH  receive byte from UART DataOut.
REQ-006 Port in_valid  input  1  from UART DataOutValid; in_data is valid.
REQ-007 Port in_ready  output  1  to UART DataOutReady; the FIFO can accept a byte.
REQ-008 Port out_data  output  WIDTH  oldest stored byte, driven to the datapath UART read mux.
REQ-009 Port out_valid  output  1  out_data holds a stored byte.
REQ-010 Port out_ready  input  1  the datapath consumes out_data (REUART strobe).
REQ-011 Port flush  input  1  synchronous clear of all stored bytes.

Function
REQ-012 A push SHALL occur on a rising edge when in_valid && in_ready && !flush; in_data SHALL be written at the write pointer.
REQ-013 A pop SHALL occur on a rising edge when out_valid && out_ready && !flush; the read pointer SHALL advance.
REQ-014 in_ready SHALL equal !full, driven from registered state only, with no combinational path from out_ready.
REQ-015 out_valid SHALL equal !empty; out_data SHALL be the entry at the read pointer and SHALL hold stable while out_valid && !out_ready.
REQ-016 Latency: a byte pushed into an empty FIFO SHALL appear on out_data/out_valid in the cycle after the push edge; there is no same-cycle bypass.
REQ-017 Pointers SHALL be log2(DEPTH)+1 bits; full when the low bits match and the MSBs differ; empty when the pointers are equal; wrap-around SHALL be seamless.
REQ-018 Simultaneous push and pop when neither full nor empty SHALL leave the occupancy unchanged and preserve order.
REQ-019 When full, in_ready=0, so a pop-and-push in the same cycle SHALL NOT occur; the push SHALL be taken on the following cycle.
REQ-020 When empty, out_ready SHALL be ignored and the pointers SHALL be unchanged.
REQ-021 flush SHALL zero both pointers on the next edge and override any push or pop in that cycle; the byte presented in that cycle SHALL be discarded.
REQ-022 Stored data SHALL be returned strictly in arrival order; no byte SHALL be lost while the handshakes are honoured.

Reset
REQ-023 While rst=0, both pointers SHALL clear asynchronously, giving out_valid=0 and in_ready=1.
REQ-024 Storage array contents SHALL NOT require reset; out_data is don't-care while out_valid=0.
REQ-025 Reset asserted mid-transfer SHALL discard all stored bytes; the first push after rst rises SHALL behave as a push into an empty FIFO.

Configuration
REQ-026 With macro UART_RX_FIFO_COUNT_EN defined, the block SHALL add the port count  output  log2(DEPTH)+1 bits, giving the registered occupancy (write pointer minus read pointer), reset value 0, and 0 on the edge after a flush.
REQ-027 Without UART_RX_FIFO_COUNT_EN, the count port and its logic SHALL be absent, with all other behaviour identical.

Verification
REQ-028 After reset, push 0x41 with out_ready=0 -> out_valid=1 one cycle later, out_data=0x41, in_ready=1.
REQ-029 Push 0x00..0x07 with no pops (DEPTH=8) -> in_ready=0 after the eighth push; a ninth byte 0xFF held on in_valid is not stored; count=8 if enabled.
REQ-030 From full, pulse out_ready for one cycle -> 0x00 popped, in_ready=1 next cycle, the held 0xFF is pushed the cycle after, and the drain order is 0x01..0x07 then 0xFF.
REQ-031 Stream 20 bytes 0x10..0x23 with in_valid and out_ready held high -> outputs 0x10..0x23 in order, pointers wrap twice, no drops, count stays at most 1.
REQ-032 With 3 bytes stored, assert flush together with in_valid (0x55) -> next cycle out_valid=0, count=0, and 0x55 is absent.
REQ-033 With 5 bytes stored, drive rst low between clock edges -> out_valid=0 and in_ready=1 immediately, before the next edge; after release, push 0x7E -> out_data=0x7E.
